// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on magnitudes, sign fix-up in FIX, results held in HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    // Handshake: start is accepted only at an edge where busy=0; busy stays
    // high for the whole operation and done pulses for one cycle when HI/LO
    // take the result. A start seen while busy is dropped, never queued.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [5:0]         cnt;
    logic [1:0]         op_q;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   raw_a;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH:0]     sh_b;

    logic               in_signed, in_neg_a, in_neg_b;
    logic [WIDTH:0]     in_mag_a, in_mag_b;
    logic               is_div, is_signed, flip;
    logic [WIDTH:0]     rem_shift;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_diff;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               div_zero;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Magnitudes carry one extra bit so |most-negative| is representable.
    assign in_signed = ~op[0];
    assign in_neg_a  = in_signed & src_a[WIDTH-1];
    assign in_neg_b  = in_signed & src_b[WIDTH-1];
    assign in_mag_a  = in_neg_a ? ({(WIDTH+1){1'b0}} - {1'b1, src_a}) : {1'b0, src_a};
    assign in_mag_b  = in_neg_b ? ({(WIDTH+1){1'b0}} - {1'b1, src_b}) : {1'b0, src_b};

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign flip      = is_signed & (sign_a ^ sign_b);

    // Divide keeps remainder in acc[2W-1:W] and dividend/quotient in acc[W-1:0].
    assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign q_bit     = (rem_shift >= sh_b);
    assign rem_diff  = rem_shift[WIDTH-1:0] - sh_b[WIDTH-1:0];

    assign product   = flip ? ({(2*WIDTH){1'b0}} - acc) : acc;
    assign quo_fix   = flip ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fix   = (is_signed & sign_a) ? ({WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH])
                                            : acc[2*WIDTH-1:WIDTH];
    assign div_zero  = (sh_b == '0);

    always_comb begin
        fix_hi = product[2*WIDTH-1:WIDTH];
        fix_lo = product[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = raw_a;
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt == 6'(WIDTH-1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            op_q        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            raw_a       <= '0;
            acc         <= '0;
            mcand       <= '0;
            sh_b        <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        sign_a      <= in_neg_a;
                        sign_b      <= in_neg_b;
                        raw_a       <= src_a;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        sh_b        <= in_mag_b;
                        if (op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, in_mag_a[WIDTH-1:0]};
                            mcand <= '0;
                        end else begin
                            acc   <= '0;
                            mcand <= {{(WIDTH-1){1'b0}}, in_mag_a};
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (is_div) begin
                        acc <= {(q_bit ? rem_diff : rem_shift[WIDTH-1:0]),
                                acc[WIDTH-2:0], q_bit};
                    end else begin
                        if (sh_b[0]) acc <= acc + mcand;
                        mcand <= mcand << 1;
                        sh_b  <= sh_b >> 1;
                    end
                end
                FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
                    if (is_div && div_zero) div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of operations with
// hand-computed HI/LO, plus sequences for protocol and reset corner cases.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic        div_by_zero;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // driver: called at a negedge, start is held across exactly one rising edge
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // counts busy samples from the current negedge until done, bounded
    task automatic wait_done(input string name, input int exp_busy);
        int busy_cycles = 0;
        bit got = 0;
        for (int i = 0; i < 45 && !got; i++) begin
            if (done) got = 1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
        check({name, "_done_seen"}, 64'(got), 64'd1);
        check({name, "_latency"}, 64'(busy_cycles), 64'(exp_busy));
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{OP_DIVU,  32'd7,        32'd3,        32'd1,        32'd2,        1'b0};
        vecs[8]  = '{OP_MULT,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};
        vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{OP_DIV,   32'h80000000, 32'd2,        32'h00000000, 32'hC0000000, 1'b0};
        vecs[14] = '{OP_MULT,  32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};

        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // table: each launch follows the previous done cycle directly (back-to-back)
        for (int i = 0; i < 15; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_accept_busy", i), 64'(busy), 64'd1);
            check($sformatf("v%0d_done_low", i), 64'(done), 64'd0);
            if (i == 7 || i == 11)
                check($sformatf("v%0d_dbz_cleared", i), 64'(div_by_zero), 64'd0);
            wait_done($sformatf("v%0d", i), 33);
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            check($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].exp_dbz));
        end
        @(negedge clk);
        check("done_drop", 64'(done), 64'd0);

        // start with other op and MTHI while busy are both ignored
        launch(OP_MULTU, 32'd3, 32'd5);
        start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("busy_hi_we_ignored", 64'(hi), 64'h0);
        wait_done("ign", 32);
        check("ign_hi", 64'(hi), 64'd0);
        check("ign_lo", 64'(lo), 64'd15);
        @(negedge clk);
        check("ign_no_second", 64'(busy), 64'd0);

        // MTHI / MTLO in idle
        hi_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'h12345678);
        check("mthi_lo_kept", 64'(lo), 64'd15);
        lo_we = 1'b1; wdata = 32'hCAFEF00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'hCAFEF00D);
        check("mtlo_hi_kept", 64'(hi), 64'h12345678);

        // start beats a simultaneous write enable
        hi_we = 1'b1; wdata = 32'hFFFF0000;
        launch(OP_MULTU, 32'd2, 32'd3);
        hi_we = 1'b0;
        check("start_wins_hi", 64'(hi), 64'h12345678);
        wait_done("sw", 33);
        check("sw_hi", 64'(hi), 64'd0);
        check("sw_lo", 64'(lo), 64'd6);

        // reset in the middle of an operation
        @(negedge clk);
        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        begin
            bit saw_done = 0;
            for (int i = 0; i < 40; i++) begin
                if (done || busy) saw_done = 1;
                @(negedge clk);
            end
            check("mid_rst_no_done", 64'(saw_done), 64'd0);
        end
        launch(OP_MULTU, 32'd3, 32'd4);
        wait_done("post_rst", 33);
        check("post_rst_lo", 64'(lo), 64'd12);
        check("post_rst_hi", 64'(hi), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
